// File: rtl/chr_ram_wr_arb_if.sv
// rtl/chr_ram_wr_arb_if.sv - requester, clear-control and RAM write-side bundle for chr_ram_wr_arb
interface chr_ram_wr_arb_if #(
   parameter int C_DAT_W = 8,
   parameter int C_ADR_W = 10
);
   logic               a_req;
   logic [C_ADR_W-1:0] a_adr;
   logic [C_DAT_W-1:0] a_dat;
   logic               a_ack;
   logic               b_req;
   logic [C_ADR_W-1:0] b_adr;
   logic [C_DAT_W-1:0] b_dat;
   logic               b_ack;
   logic               clr;
   logic [C_DAT_W-1:0] fill;
   logic               busy;
   logic               done;
   logic               we;
   logic [C_ADR_W-1:0] wa;
   logic [C_DAT_W-1:0] wd;

   modport master (
      output a_req, a_adr, a_dat, b_req, b_adr, b_dat, clr, fill,
      input  a_ack, b_ack, busy, done, we, wa, wd
   );

   modport slave (
      input  a_req, a_adr, a_dat, b_req, b_adr, b_dat, clr, fill,
      output a_ack, b_ack, busy, done, we, wa, wd
   );
endinterface

// File: rtl/chr_ram_wr_arb.sv
// rtl/chr_ram_wr_arb.sv - character RAM write-port arbiter (A/B round-robin) with built-in clear engine
// Define CHR_RAM_WR_ARB_FIXED_PRI_EN for fixed A-over-B priority instead of round-robin.
module chr_ram_wr_arb #(
   parameter int C_DAT_W = 8,
   parameter int C_ADR_W = 10
) (
   input logic             ck,
   input logic             xar,
   chr_ram_wr_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   localparam logic [C_ADR_W:0] CNT_LAST = {1'b0, {C_ADR_W{1'b1}}};
   localparam logic [C_ADR_W:0] CNT_ONE  = {{C_ADR_W{1'b0}}, 1'b1};

   state_t             state, state_d;
   logic [C_ADR_W:0]   cnt, cnt_d;
   logic [C_DAT_W-1:0] fill_q, fill_d;
   logic               we_q, we_d;
   logic [C_ADR_W-1:0] wa_q, wa_d;
   logic [C_DAT_W-1:0] wd_q, wd_d;
   logic               a_ack_q, a_ack_d;
   logic               b_ack_q, b_ack_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               a_elig, b_elig, pick_a;

   // A requester acknowledged this cycle sits out the next edge, so a held REQ is written once.
   assign a_elig = bus.a_req && !a_ack_q;
   assign b_elig = bus.b_req && !b_ack_q;

`ifdef CHR_RAM_WR_ARB_FIXED_PRI_EN
   assign pick_a = a_elig;
`else
   logic rr_b, rr_b_d;   // 1: B wins the next tie
   assign pick_a = a_elig && (!b_elig || !rr_b);
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      fill_d  = fill_q;
      we_d    = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      a_ack_d = 1'b0;
      b_ack_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifndef CHR_RAM_WR_ARB_FIXED_PRI_EN
      rr_b_d  = rr_b;
`endif
      unique case (state)
         IDLE: begin
            if (bus.clr) begin
               state_d = CLEAR;
               fill_d  = bus.fill;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else if (pick_a) begin
               we_d    = 1'b1;
               wa_d    = bus.a_adr;
               wd_d    = bus.a_dat;
               a_ack_d = 1'b1;
`ifndef CHR_RAM_WR_ARB_FIXED_PRI_EN
               if (b_elig) rr_b_d = 1'b1;
`endif
            end else if (b_elig) begin
               we_d    = 1'b1;
               wa_d    = bus.b_adr;
               wd_d    = bus.b_dat;
               b_ack_d = 1'b1;
`ifndef CHR_RAM_WR_ARB_FIXED_PRI_EN
               if (a_elig) rr_b_d = 1'b0;
`endif
            end
         end
         CLEAR: begin
            we_d   = 1'b1;
            wa_d   = cnt[C_ADR_W-1:0];
            wd_d   = fill_q;
            cnt_d  = cnt + CNT_ONE;
            busy_d = 1'b1;
            if (cnt == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge xar) begin
      if (!xar) begin
         state   <= IDLE;
         cnt     <= '0;
         fill_q  <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifndef CHR_RAM_WR_ARB_FIXED_PRI_EN
         rr_b    <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         fill_q  <= fill_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifndef CHR_RAM_WR_ARB_FIXED_PRI_EN
         rr_b    <= rr_b_d;
`endif
      end
   end

   assign bus.we    = we_q;
   assign bus.wa    = wa_q;
   assign bus.wd    = wd_q;
   assign bus.a_ack = a_ack_q;
   assign bus.b_ack = b_ack_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_chr_ram_wr_arb.sv
// tb/tb_chr_ram_wr_arb.sv - directed table-driven bench for chr_ram_wr_arb (C_ADR_W=4 build)
module tb_chr_ram_wr_arb;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NV = 12;

   typedef struct {
      logic          a_req;
      logic [AW-1:0] a_adr;
      logic [DW-1:0] a_dat;
      logic          b_req;
      logic [AW-1:0] b_adr;
      logic [DW-1:0] b_dat;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          a_ack;
      logic          b_ack;
   } vec_t;

   logic ck  = 1'b0;
   logic xar = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[NV];

   chr_ram_wr_arb_if #(.C_DAT_W(DW), .C_ADR_W(AW)) bus ();

   chr_ram_wr_arb #(.C_DAT_W(DW), .C_ADR_W(AW)) dut (
      .ck  (ck),
      .xar (xar),
      .bus (bus)
   );

   always #5 ck = ~ck;

   // Packed as {we, wa, wd, a_ack, b_ack, busy, done}
   task automatic chk(input string name, input logic [AW+DW+4:0] exp);
      logic [AW+DW+4:0] act;
      act = {bus.we, bus.wa, bus.wd, bus.a_ack, bus.b_ack, bus.busy, bus.done};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (we,wa,wd,a_ack,b_ack,busy,done)", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   function automatic vec_t mk(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                               input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic ak, input logic bk);
      vec_t v;
      v.a_req = ar; v.a_adr = aa; v.a_dat = ad;
      v.b_req = br; v.b_adr = ba; v.b_dat = bd;
      v.we = we; v.wa = wa; v.wd = wd; v.a_ack = ak; v.b_ack = bk;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(1, 4'hC, 8'h41, 0, 4'h0, 8'h00,  1, 4'hC, 8'h41, 1, 0);
      vecs[1]  = mk(1, 4'hC, 8'h41, 0, 4'h0, 8'h00,  0, 4'hC, 8'h41, 0, 0);
      vecs[2]  = mk(0, 4'h0, 8'h00, 1, 4'h3, 8'hB3,  1, 4'h3, 8'hB3, 0, 1);
      vecs[3]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 8'h00,  0, 4'h3, 8'hB3, 0, 0);
      vecs[4]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h5, 8'hA5, 1, 0);
      vecs[5]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h6, 8'hB6, 0, 1);
      vecs[6]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h5, 8'hA5, 1, 0);
      vecs[7]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h6, 8'hB6, 0, 1);
      vecs[8]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 8'h00,  0, 4'h6, 8'hB6, 0, 0);
`ifdef CHR_RAM_WR_ARB_FIXED_PRI_EN
      vecs[9]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h5, 8'hA5, 1, 0);
      vecs[10] = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h6, 8'hB6, 0, 1);
      vecs[11] = mk(0, 4'h0, 8'h00, 0, 4'h0, 8'h00,  0, 4'h6, 8'hB6, 0, 0);
`else
      // Last tie went to A at row 4, so the next tie belongs to B
      vecs[9]  = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h6, 8'hB6, 0, 1);
      vecs[10] = mk(1, 4'h5, 8'hA5, 1, 4'h6, 8'hB6,  1, 4'h5, 8'hA5, 1, 0);
      vecs[11] = mk(0, 4'h0, 8'h00, 0, 4'h0, 8'h00,  0, 4'h5, 8'hA5, 0, 0);
`endif

      bus.a_req = 0; bus.a_adr = '0; bus.a_dat = '0;
      bus.b_req = 0; bus.b_adr = '0; bus.b_dat = '0;
      bus.clr = 0;   bus.fill = '0;

      repeat (3) @(posedge ck);
      #1;
      chk("reset", '0);
      xar = 1'b1;

      for (int i = 0; i < NV; i++) begin
         bus.a_req = vecs[i].a_req; bus.a_adr = vecs[i].a_adr; bus.a_dat = vecs[i].a_dat;
         bus.b_req = vecs[i].b_req; bus.b_adr = vecs[i].b_adr; bus.b_dat = vecs[i].b_dat;
         step();
         chk($sformatf("vec%0d", i),
             {vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a_ack, vecs[i].b_ack, 2'b00});
      end

      // Clear with A pending on the same edge; CLR re-pulse, FILL change and a withdrawn B inside
      bus.clr = 1; bus.fill = 8'h20;
      bus.a_req = 1; bus.a_adr = 4'h9; bus.a_dat = 8'h99;
      step();
      chk("clr_start", {1'b0, vecs[NV-1].wa, vecs[NV-1].wd, 4'b0010});
      bus.clr = 0;
      for (int k = 0; k < 16; k++) begin
         if (k == 3) begin bus.clr = 1; bus.fill = 8'h55; end
         if (k == 4) bus.clr = 0;
         if (k == 5) begin bus.b_req = 1; bus.b_adr = 4'h1; bus.b_dat = 8'h11; end
         if (k == 6) bus.b_req = 0;
         step();
         chk($sformatf("clr_wr%0d", k), {1'b1, 4'(k), 8'h20, 4'b0010});
      end
      step();
      chk("clr_done", {1'b0, 4'hF, 8'h20, 4'b0001});
      step();
      chk("a_after_clr", {1'b1, 4'h9, 8'h99, 4'b1000});
      bus.a_req = 0;
      step();
      chk("idle_after", {1'b0, 4'h9, 8'h99, 4'b0000});

      // Reset while the clear engine is at address 7
      bus.clr = 1; bus.fill = 8'h33;
      step();
      chk("clr2_start", {1'b0, 4'h9, 8'h99, 4'b0010});
      bus.clr = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("clr2_wr%0d", k), {1'b1, 4'(k), 8'h33, 4'b0010});
      end
      xar = 1'b0;
      #1;
      chk("async_rst", '0);
      step();
      xar = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("post_rst%0d", k), '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
